btn_event_gen: RTL and testbench
================================

Name: btn_event_gen

Overview:
- Multi-channel push-button front end; parametrised successor of the single-channel level-to-pulse converter.
- Per channel: 2-flop synchroniser, counter-based debounce, one-cycle press/release pulses, long-press detection with auto-repeat.
- Sits between board pushbuttons and the mode/colour control FSMs of the mood-lighting core.
- Channels are fully independent.

Parameters:
- NUM_CH, 4: number of button channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a level change. 10 ms at 50 MHz. Must be >= 1.
- LONG_CYCLES, 50000000: cycles after press_pulse until long_pulse (1 s).
- REPEAT_CYCLES, 10000000: auto-repeat period after long_pulse. 0 disables repeat.
- ACTIVE_LOW, 1: 1 means a button is pressed when btn_in = 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low. All state is cleared on the rising clk edge where rst_n = 0.
- en  in  1  event enable. When 0, all pulse outputs are held 0. Debounce and counters keep running.
- btn_in  in  NUM_CH  raw asynchronous button levels.
- btn_level  out  NUM_CH  debounced pressed state (1 = pressed), registered.
- press_pulse  out  NUM_CH  one-cycle pulse on accepted press.
- release_pulse  out  NUM_CH  one-cycle pulse on accepted release.
- long_pulse  out  NUM_CH  one-cycle pulse on long-press threshold.
- repeat_pulse  out  NUM_CH  one-cycle auto-repeat pulses while held past long.
- any_press  out  1  registered OR of press_pulse.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops = inactive level (ACTIVE_LOW ? 1 : 0).
  - Debounce counters, hold counters and per-channel FSMs cleared; FSMs to IDLE.
- Synchroniser: sync1 <= btn_in; sync2 <= sync1. raw_pressed = sync2 XOR ACTIVE_LOW.
- Debounce, per channel:
  - When raw_pressed != btn_level, db_cnt increments. Otherwise db_cnt clears.
  - When db_cnt would reach DEBOUNCE_CYCLES, btn_level toggles and db_cnt clears in the same edge.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: btn_in changes before edge E and stays stable. Then btn_level changes at edge E+1+DEBOUNCE_CYCLES, and press_pulse/release_pulse are high for the cycle after that edge (same edge as btn_level).
- Per-channel FSM:
  - IDLE: btn_level rises -> HELD. Emit press_pulse, clear hold_cnt.
  - HELD: hold_cnt increments each cycle.
    - hold_cnt == LONG_CYCLES-1 -> LONG. Emit long_pulse, clear hold_cnt.
    - btn_level falls -> IDLE. Emit release_pulse.
  - LONG: REPEAT_CYCLES > 0 and hold_cnt == REPEAT_CYCLES-1 -> emit repeat_pulse, clear hold_cnt, stay in LONG.
    - btn_level falls -> IDLE. Emit release_pulse.
    - REPEAT_CYCLES = 0: hold_cnt saturates and no repeat is emitted.
  - Illegal state encoding -> IDLE.
- Release has priority: when release and a long/repeat threshold coincide, only release_pulse fires.
- At most one of press/release/long/repeat per channel per cycle.
- Hold counter width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
- en = 0 masks all four pulse outputs and any_press. FSM and counters still advance, so a long threshold crossed while en = 0 is lost, not deferred. btn_level is not masked.
- any_press is registered one cycle after press_pulse.
- Reset mid-press: everything clears. A button still held when rst_n releases is seen as a new press after full latency.
- Simultaneous presses on several channels each produce their own pulse in the same cycle.

Test Plan:
1. Reset/idle: NUM_CH=4, DEBOUNCE_CYCLES=4, LONG=20, REPEAT=8, btn_in=4'hF, rst_n low 3 cycles -> all outputs 0, btn_level=0 for 50 cycles.
2. Clean press: btn_in[0] 1->0 held -> btn_level[0]=1 and press_pulse[0] high exactly 1 cycle, 5 edges after change; any_press one cycle later. Other channels stay 0.
3. Glitch reject: btn_in[1] low for 3 cycles then high -> no press_pulse, btn_level[1] stays 0. Low for 4+ cycles -> press accepted.
4. Long and repeat: hold btn_in[2] low 60 cycles -> long_pulse 20 cycles after press_pulse, then repeat_pulse every 8 cycles (at +28, +36, ...). Release -> single release_pulse, no repeat after it.
5. Enable mask: en=0 during press of ch3 -> press_pulse[3]=0, btn_level[3]=1. Raise en before LONG -> long_pulse[3] still fires on time.
6. Reset mid-hold: ch0 in LONG, assert rst_n=0 1 cycle with btn still low -> outputs 0, then press_pulse[0] after 5 edges, long after 20 more. Also check REPEAT_CYCLES=0 build gives no repeat_pulse.

Source files
------------

// File: rtl/btn_event_gen.sv
// Multi-channel push-button front end: synchroniser, debounce, press/release pulses,
// long-press detection and auto-repeat. Channels are fully independent.
module btn_event_gen #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] repeat_pulse,
    output logic              any_press
);

    localparam int unsigned DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldMax  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW       = $clog2(HoldMax + 1);
    localparam int unsigned RepLastI = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    localparam logic [DW-1:0] DbLast   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LongLast = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] RepLast  = HW'(RepLastI);

    typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic          sync1_q, sync2_q;
        logic          raw_pressed;
        logic [DW-1:0] db_cnt_d, db_cnt_q;
        logic          level_d, level_q;
        logic          rise, fall;
        state_e        state_d, state_q;
        logic [HW-1:0] hold_d, hold_q;
        logic          press_d, release_d, long_d, repeat_d;
        logic          press_q, release_q, long_q, repeat_q;

        assign raw_pressed = sync2_q ^ ACTIVE_LOW;

        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            if (raw_pressed != level_q) begin
                if (db_cnt_q == DbLast) begin
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
        end

        // Events are taken from the debounce next state so pulses land on the same edge
        // as the level change.
        assign rise = ~level_q & level_d;
        assign fall = level_q & ~level_d;

        always_comb begin
            state_d   = state_q;
            hold_d    = hold_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StHeld;
                        hold_d  = '0;
                        press_d = 1'b1;
                    end
                end
                StHeld: begin
                    if (fall) begin
                        state_d   = StIdle;
                        release_d = 1'b1;
                    end else if (hold_q == LongLast) begin
                        state_d = StLong;
                        hold_d  = '0;
                        long_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                StLong: begin
                    if (fall) begin
                        state_d   = StIdle;
                        release_d = 1'b1;
                    end else if ((REPEAT_CYCLES != 0) && (hold_q == RepLast)) begin
                        hold_d   = '0;
                        repeat_d = 1'b1;
                    end else if (hold_q != {HW{1'b1}}) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    hold_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q   <= ACTIVE_LOW;
                sync2_q   <= ACTIVE_LOW;
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                state_q   <= StIdle;
                hold_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                sync1_q   <= btn_in[c];
                sync2_q   <= sync1_q;
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                state_q   <= state_d;
                hold_q    <= hold_d;
                press_q   <= press_d & en;
                release_q <= release_d & en;
                long_q    <= long_d & en;
                repeat_q  <= repeat_d & en;
            end
        end

        assign btn_level[c]     = level_q;
        assign press_pulse[c]   = press_q;
        assign release_pulse[c] = release_q;
        assign long_pulse[c]    = long_q;
        assign repeat_pulse[c]  = repeat_q;
    end

    logic any_press_d, any_press_q;

    assign any_press_d = en & (|press_pulse);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen: vector table for press/release/glitch/enable,
// hand sequences for long-press, auto-repeat, release priority and reset mid-hold.
module tb_btn_event_gen;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b1;
    logic [NCH-1:0] btn_in = 4'hF;

    logic [NCH-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic           any_press;
    logic [NCH-1:0] lvl_nr, prs_nr, rel_nr, lng_nr, rpt_nr;
    logic           any_nr;

    btn_event_gen #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .btn_in(btn_in),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .any_press(any_press)
    );

    btn_event_gen #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .en(en), .btn_in(btn_in),
        .btn_level(lvl_nr), .press_pulse(prs_nr), .release_pulse(rel_nr),
        .long_pulse(lng_nr), .repeat_pulse(rpt_nr), .any_press(any_nr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nr_rep_cnt = 0;

    always @(negedge clk) if (rst_n && |rpt_nr) nr_rep_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string    name;
        logic     rst_n;
        logic     en;
        logic [3:0] btn;
        int       n;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] rpt;
        logic     any;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic e, input logic [3:0] b,
                       input int n, input logic [3:0] lvl, input logic [3:0] prs,
                       input logic [3:0] rel, input logic any);
        vec_t v;
        v.name = name; v.rst_n = r; v.en = e; v.btn = b; v.n = n;
        v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = 4'h0; v.rpt = 4'h0; v.any = any;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] prs_acc, rel_acc, lng_acc, rpt_acc;
        logic       any_acc;
        logic       found;
        logic       exp_long, exp_rep, exp_rel;

        // Pulse columns are the OR over the row's window; level is sampled at its end.
        add("reset",      1'b0, 1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0, 1'b0);
        add("idle",       1'b1, 1'b1, 4'hF, 50, 4'h0, 4'h0, 4'h0, 1'b0);
        add("p0_wait",    1'b1, 1'b1, 4'hE, 5,  4'h0, 4'h0, 4'h0, 1'b0);
        add("p0_edge",    1'b1, 1'b1, 4'hE, 1,  4'h1, 4'h1, 4'h0, 1'b0);
        add("p0_any",     1'b1, 1'b1, 4'hE, 1,  4'h1, 4'h0, 4'h0, 1'b1);
        add("p0_hold",    1'b1, 1'b1, 4'hE, 3,  4'h1, 4'h0, 4'h0, 1'b0);
        add("g1_glitch",  1'b1, 1'b1, 4'hC, 3,  4'h1, 4'h0, 4'h0, 1'b0);
        add("g1_settle",  1'b1, 1'b1, 4'hE, 6,  4'h1, 4'h0, 4'h0, 1'b0);
        add("r0_wait",    1'b1, 1'b1, 4'hF, 5,  4'h1, 4'h0, 4'h0, 1'b0);
        add("r0_edge",    1'b1, 1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h1, 1'b0);
        add("r0_after",   1'b1, 1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0, 1'b0);
        add("p1_wait",    1'b1, 1'b1, 4'hD, 5,  4'h0, 4'h0, 4'h0, 1'b0);
        add("p1_edge",    1'b1, 1'b1, 4'hD, 1,  4'h2, 4'h2, 4'h0, 1'b0);
        add("p1_any",     1'b1, 1'b1, 4'hD, 1,  4'h2, 4'h0, 4'h0, 1'b1);
        add("r1_wait",    1'b1, 1'b1, 4'hF, 5,  4'h2, 4'h0, 4'h0, 1'b0);
        add("r1_edge",    1'b1, 1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h2, 1'b0);
        add("p01_wait",   1'b1, 1'b1, 4'hC, 5,  4'h0, 4'h0, 4'h0, 1'b0);
        add("p01_edge",   1'b1, 1'b1, 4'hC, 1,  4'h3, 4'h3, 4'h0, 1'b0);
        add("p01_any",    1'b1, 1'b1, 4'hC, 1,  4'h3, 4'h0, 4'h0, 1'b1);
        add("r01_wait",   1'b1, 1'b1, 4'hF, 5,  4'h3, 4'h0, 4'h0, 1'b0);
        add("r01_edge",   1'b1, 1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h3, 1'b0);
        add("en_press3",  1'b1, 1'b0, 4'h7, 6,  4'h8, 4'h0, 4'h0, 1'b0);
        add("en_rel3",    1'b1, 1'b0, 4'hF, 6,  4'h0, 4'h0, 4'h0, 1'b0);
        add("en_restore", 1'b1, 1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0, 1'b0);

        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            en     = vecs[i].en;
            btn_in = vecs[i].btn;
            prs_acc = '0; rel_acc = '0; lng_acc = '0; rpt_acc = '0; any_acc = 1'b0;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                prs_acc |= press_pulse;
                rel_acc |= release_pulse;
                lng_acc |= long_pulse;
                rpt_acc |= repeat_pulse;
                any_acc |= any_press;
            end
            chk({vecs[i].name, ".level"}, 32'(btn_level), 32'(vecs[i].lvl));
            chk({vecs[i].name, ".press"}, 32'(prs_acc), 32'(vecs[i].prs));
            chk({vecs[i].name, ".release"}, 32'(rel_acc), 32'(vecs[i].rel));
            chk({vecs[i].name, ".long"}, 32'(lng_acc), 32'(vecs[i].lng));
            chk({vecs[i].name, ".repeat"}, 32'(rpt_acc), 32'(vecs[i].rpt));
            chk({vecs[i].name, ".any"}, 32'(any_acc), 32'(vecs[i].any));
        end

        // Long press and auto-repeat on ch2; release lands on a repeat-due edge (t=52).
        btn_in = 4'hB;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            if (press_pulse[2]) begin
                found = 1'b1;
                chk("t4.press_latency", 32'(k), 32'd6);
            end
        end
        chk("t4.press_seen", 32'(found), 32'd1);
        for (int t = 1; t <= 60; t++) begin
            if (t == 47) btn_in = 4'hF;
            tick();
            exp_long = (t == 20);
            exp_rep  = (t > 20) && (t < 52) && ((t - 20) % 8 == 0);
            exp_rel  = (t == 52);
            chk($sformatf("t4.ch2@%0d", t),
                32'({press_pulse[2], release_pulse[2], long_pulse[2], repeat_pulse[2]}),
                32'({1'b0, exp_rel, exp_long, exp_rep}));
            chk($sformatf("t4.norep@%0d", t),
                32'({rel_nr[2], lng_nr[2], rpt_nr[2]}), 32'({exp_rel, exp_long, 1'b0}));
        end

        // Press on ch3 while masked; long still fires on time once enabled.
        en = 1'b0;
        btn_in = 4'h7;
        prs_acc = '0; any_acc = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            prs_acc |= press_pulse;
            any_acc |= any_press;
        end
        chk("t5.level3", 32'(btn_level[3]), 32'd1);
        chk("t5.press_masked", 32'(prs_acc), 32'd0);
        chk("t5.any_masked", 32'(any_acc), 32'd0);
        en = 1'b1;
        for (int t = 1; t <= 35; t++) begin
            if (t == 26) btn_in = 4'hF;
            tick();
            exp_long = (t == 20);
            exp_rep  = (t == 28);
            exp_rel  = (t == 31);
            chk($sformatf("t5.ch3@%0d", t),
                32'({press_pulse[3], release_pulse[3], long_pulse[3], repeat_pulse[3], any_press}),
                32'({1'b0, exp_rel, exp_long, exp_rep, 1'b0}));
        end

        // Reset while ch0 sits in LONG with the button still held.
        btn_in = 4'hE;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            if (press_pulse[0]) found = 1'b1;
        end
        chk("t6.first_press", 32'(found), 32'd1);
        for (int t = 1; t <= 23; t++) begin
            tick();
            chk($sformatf("t6.long@%0d", t), 32'(long_pulse[0]), 32'(t == 20));
        end
        rst_n = 1'b0;
        tick();
        chk("t6.rst_level", 32'(btn_level), 32'd0);
        chk("t6.rst_pulses",
            32'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'd0);
        chk("t6.rst_any", 32'(any_press), 32'd0);
        chk("t6.rst_level_nr", 32'(lvl_nr), 32'd0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            if (press_pulse[0]) begin
                found = 1'b1;
                chk("t6.repress_latency", 32'(k), 32'd6);
            end
        end
        chk("t6.repress_seen", 32'(found), 32'd1);
        for (int t = 1; t <= 21; t++) begin
            tick();
            chk($sformatf("t6.relong@%0d", t), 32'({long_pulse[0], repeat_pulse[0]}),
                32'({t == 20, 1'b0}));
        end
        btn_in = 4'hF;
        for (int k = 0; k < 10; k++) tick();
        chk("t6.released", 32'(btn_level), 32'd0);
        chk("norep.never_repeats", 32'(nr_rep_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
